multicycle_control: RTL

- Multi-cycle MIPS controller FSM that sequences a shared-memory datapath (single memory for instructions and data, IR/ALUOut/PC registers) over 3-5 cycles per instruction.
- Decodes op/funct into per-state control strobes and handles a ready handshake with the memory.
- A watchdog counter traps a stalled memory into a sticky FAULT state.

---
 rtl/multicycle_control.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS controller: sequences a shared-memory datapath with a ready
// handshake. A watchdog traps a stalled memory access into a sticky FAULT state.
module multicycle_control #(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CNT_W   = 5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_en,
   output logic       iord,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [2:0] alu_ctrl,
   output logic [1:0] pc_src,
   output logic       retire,
   output logic       illegal,
   output logic       fault,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_RTEX   = 4'd6,  S_RTWB   = 4'd7,
      S_BEQEX  = 4'd8,  S_ADDIEX = 4'd9,  S_ADDIWB = 4'd10, S_JEX    = 4'd11,
      S_FAULT  = 4'd15
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [CNT_W-1:0] LIMIT = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

   state_t           cur_state, nxt_state;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             mem_wait;

   function automatic logic rt_legal(input logic [5:0] f);
      return (f == 6'b100000) || (f == 6'b100010) || (f == 6'b100100) ||
             (f == 6'b100101) || (f == 6'b101010);
   endfunction

   function automatic logic [2:0] rt_alu(input logic [5:0] f);
      case (f)
         6'b100010: return 3'b110;
         6'b100100: return 3'b000;
         6'b100101: return 3'b001;
         6'b101010: return 3'b111;
         default:   return 3'b010;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         cur_state <= S_FETCH;
         cnt       <= '0;
      end else begin
         cur_state <= nxt_state;
         cnt       <= cnt_nxt;
      end
   end

   assign state = cur_state;

   always_comb begin
      nxt_state  = cur_state;
      cnt_nxt    = '0;
      mem_wait   = 1'b0;
      pc_en      = 1'b0;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_ctrl   = 3'b010;
      pc_src     = 2'b00;
      retire     = 1'b0;
      illegal    = 1'b0;
      fault      = 1'b0;

      case (cur_state)
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            if (mem_ready) begin
               ir_write  = 1'b1;
               pc_en     = 1'b1;
               nxt_state = S_DECODE;
            end else begin
               mem_wait = 1'b1;
            end
         end
         S_DECODE: begin
            alu_src_b = 2'b11;
            case (op)
               OP_LW, OP_SW: nxt_state = S_MEMADR;
               OP_BEQ:       nxt_state = S_BEQEX;
               OP_ADDI:      nxt_state = S_ADDIEX;
               OP_J:         nxt_state = S_JEX;
               OP_RTYPE: begin
                  if (rt_legal(funct)) begin
                     nxt_state = S_RTEX;
                  end else begin
                     illegal   = 1'b1;
                     nxt_state = S_FETCH;
                  end
               end
               default: begin
                  illegal   = 1'b1;
                  nxt_state = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            nxt_state = (op == OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            mem_read = 1'b1;
            iord     = 1'b1;
            if (mem_ready) nxt_state = S_MEMWB;
            else           mem_wait  = 1'b1;
         end
         S_MEMWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            retire     = 1'b1;
            nxt_state  = S_FETCH;
         end
         S_MEMWR: begin
            mem_write = 1'b1;
            iord      = 1'b1;
            if (mem_ready) begin
               retire    = 1'b1;
               nxt_state = S_FETCH;
            end else begin
               mem_wait = 1'b1;
            end
         end
         S_RTEX: begin
            alu_src_a = 1'b1;
            alu_ctrl  = rt_alu(funct);
            nxt_state = S_RTWB;
         end
         S_RTWB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
            retire    = 1'b1;
            alu_ctrl  = rt_alu(funct);
            nxt_state = S_FETCH;
         end
         S_BEQEX: begin
            alu_src_a = 1'b1;
            alu_ctrl  = 3'b110;
            pc_src    = 2'b01;
            pc_en     = zero;
            retire    = 1'b1;
            nxt_state = S_FETCH;
         end
         S_ADDIEX: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            nxt_state = S_ADDIWB;
         end
         S_ADDIWB: begin
            reg_write = 1'b1;
            retire    = 1'b1;
            nxt_state = S_FETCH;
         end
         S_JEX: begin
            pc_src    = 2'b10;
            pc_en     = 1'b1;
            retire    = 1'b1;
            nxt_state = S_FETCH;
         end
         S_FAULT: fault = 1'b1;
         default: nxt_state = S_FAULT;
      endcase

      // A ready in the limit cycle has already chosen the normal transition above.
      if (mem_wait) begin
         if (TIMEOUT != 0 && cnt == LIMIT) nxt_state = S_FAULT;
         else                              cnt_nxt   = cnt + 1'b1;
      end

      if (reset) begin
         pc_en      = 1'b0;
         iord       = 1'b0;
         mem_read   = 1'b0;
         mem_write  = 1'b0;
         ir_write   = 1'b0;
         reg_dst    = 1'b0;
         mem_to_reg = 1'b0;
         reg_write  = 1'b0;
         alu_src_a  = 1'b0;
         alu_src_b  = 2'b00;
         alu_ctrl   = 3'b000;
         pc_src     = 2'b00;
         retire     = 1'b0;
         illegal    = 1'b0;
         fault      = 1'b0;
      end
   end

endmodule
